serial_parity_checker: RTL and testbench
========================================

// Module: serial_parity_checker
// PURPOSE
//   Receive-side companion to the serial parity generator. Samples a serial
//   frame of DATA_W data bits followed by one parity bit. Checks the parity and
//   presents the assembled word with a one-cycle valid strobe.
//   Keeps a saturating count of parity errors. Sits at the receiving end of the
//   serial link, feeding parallel data and error status to downstream logic.
// PARAMETERS
//   DATA_W      8  data bits per frame (>=1)
//   ODD_PARITY  0  0: XOR of all DATA_W+1 bits must be 0 (matches generator output);
//                  1: XOR of all DATA_W+1 bits must be 1
//   CNT_W       8  width of the saturating error counter
// PORTS
//   clk         in   1       rising-edge clock
//   rstn        in   1       asynchronous, active-low reset
//   start       in   1       frame-start strobe, sampled in IDLE only
//   D_in        in   1       serial data; LSB first, then parity bit
//   data_out    out  DATA_W  last received word, held until next frame completes
//   data_valid  out  1       1-cycle pulse: data_out/parity_err updated
//   parity_err  out  1       parity result of last frame, held with data_out
//   err_count   out  CNT_W   saturating count of frames with parity_err=1
//   busy        out  1       1 in DATA or PARITY state
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE; shift reg, bit counter and running parity
//     cleared; data_out=0, data_valid=0, parity_err=0, err_count=0, busy=0.
//   FSM states and transitions:
//     IDLE   -> DATA on edge where start=1. D_in is ignored on that edge.
//               Running parity is cleared to 0 and the bit counter to 0.
//     DATA   -> each edge: shift D_in into bit[cnt], par ^= D_in, cnt++.
//               After DATA_W bits -> PARITY.
//     PARITY -> one edge: sample parity bit p, then -> IDLE.
//               On that edge: data_out <= assembled word.
//               parity_err <= ((par ^ p) != ODD_PARITY). data_valid <= 1.
//               err_count increments if parity_err is set, saturating at 2^CNT_W-1.
//   Latency: start on edge 0 -> data bits on edges 1..DATA_W -> parity bit on
//     edge DATA_W+1 -> data_valid high for the cycle following edge DATA_W+1.
//   data_valid is 0 on every other edge. It never stays high for 2 consecutive cycles.
//   start while busy=1: ignored. It does not restart or extend the frame.
//   start in the cycle data_valid is high: accepted, because state is already IDLE.
//     This allows back-to-back frames with one start cycle between them.
//   busy=1 from the edge after start is accepted through the parity edge, exclusive.
//   Reset mid-frame: the partial frame is discarded; no data_valid is produced.
//     data_out, parity_err and err_count return to 0.
//   err_count never wraps. At saturation, further errors leave it unchanged.
// TESTING (DATA_W=8 unless stated)
//   1. start, data 0xA5 LSB first, parity 0 -> data_valid pulse 1 cycle after
//      the parity edge; data_out=0xA5, parity_err=0, err_count=0.
//   2. start, data 0xA5, parity 1 -> parity_err=1, err_count=1.
//      Then a frame 0x01 with parity 1 -> parity_err=0, err_count stays 1.
//   3. start pulsed again on data bit 3 -> ignored.
//      Exactly one data_valid pulse occurs, at the normal time, with the correct data_out.
//   4. rstn low during data bit 5 -> all outputs 0 immediately; no data_valid.
//      Next full frame 0x3C with parity 0 is received correctly.
//   5. CNT_W=2: 5 consecutive bad-parity frames -> err_count 1,2,3,3,3.
//   6. ODD_PARITY=1: data 0x00 with parity 1 -> parity_err=0.
//      Data 0x00 with parity 0 -> parity_err=1.
//      Back-to-back frames with start in the data_valid cycle are both received.

Source files
------------

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_W data bits LSB first, then one parity bit.
// Presents the assembled word with a one-cycle valid strobe and a saturating error count.
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              D_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam int   CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic ODD = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                dv_q, dv_d;
  logic                perr_q, perr_d;
  logic [CNT_W-1:0]    errc_q, errc_d;
  logic                perr_now;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    data_out_d = data_out_q;
    dv_d       = 1'b0;
    perr_d     = perr_q;
    errc_d     = errc_q;
    perr_now   = ((par_q ^ D_in) != ODD);
    case (state_q)
      IDLE: begin
        // D_in on the start edge is not part of the frame
        if (start) begin
          state_d = DATA;
          par_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shreg_d[cnt_q] = D_in;
        par_d          = par_q ^ D_in;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = PARITY;
      end
      PARITY: begin
        data_out_d = shreg_q;
        perr_d     = perr_now;
        dv_d       = 1'b1;
        if (perr_now && (errc_q != '1)) errc_d = errc_q + CNT_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      errc_q     <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      data_out_q <= data_out_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      errc_q     <= errc_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign err_count  = errc_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench: u0 default config, u1 with a 2-bit error counter, u2 odd parity.
// All three share stimulus; each test checks the instance relevant to it.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, start, D_in;
  logic [7:0] data0, data1, data2;
  logic       dv0, dv1, dv2, perr0, perr1, perr2, busy0, busy1, busy2;
  logic [7:0] errc0, errc2;
  logic [1:0] errc1;

  int total = 0;
  int bad   = 0;

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(8)) u0 (
    .clk(clk), .rstn(rstn), .start(start), .D_in(D_in), .data_out(data0),
    .data_valid(dv0), .parity_err(perr0), .err_count(errc0), .busy(busy0));
  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(2)) u1 (
    .clk(clk), .rstn(rstn), .start(start), .D_in(D_in), .data_out(data1),
    .data_valid(dv1), .parity_err(perr1), .err_count(errc1), .busy(busy1));
  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(8)) u2 (
    .clk(clk), .rstn(rstn), .start(start), .D_in(D_in), .data_out(data2),
    .data_valid(dv2), .parity_err(perr2), .err_count(errc2), .busy(busy2));

  // Caller sets start=1 at a negedge, then calls this. Returns at the negedge
  // following the parity edge, i.e. inside the data_valid cycle.
  task automatic drive_frame(input logic [7:0] d, input logic p, input int restart_at,
                             output int stray);
    stray = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      D_in  = d[i];
      start = (i == restart_at);
      @(negedge clk);
      if (dv0) stray++;
    end
    start = 1'b0;
    D_in  = p;
    @(negedge clk);
    D_in  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; start = 1'b0; D_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (dv0 !== 1'b0)    begin bad++; $display("FAIL reset_dv got=%0b exp=0", dv0); end
    total++; if (data0 !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data0); end
    total++; if (perr0 !== 1'b0)  begin bad++; $display("FAIL reset_perr got=%0b exp=0", perr0); end
    total++; if (errc0 !== 8'd0)  begin bad++; $display("FAIL reset_errc got=%0d exp=0", errc0); end
    total++; if (busy0 !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy0); end
  endtask

  task automatic test_basic();
    int stray;
    @(negedge clk); start = 1'b1;
    drive_frame(8'hA5, 1'b0, -1, stray);
    total++; if (stray != 0)      begin bad++; $display("FAIL basic_early_dv got=%0d exp=0", stray); end
    total++; if (dv0 !== 1'b1)    begin bad++; $display("FAIL basic_dv got=%0b exp=1", dv0); end
    total++; if (data0 !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", data0); end
    total++; if (perr0 !== 1'b0)  begin bad++; $display("FAIL basic_perr got=%0b exp=0", perr0); end
    total++; if (errc0 !== 8'd0)  begin bad++; $display("FAIL basic_errc got=%0d exp=0", errc0); end
    total++; if (busy0 !== 1'b0)  begin bad++; $display("FAIL basic_busy got=%0b exp=0", busy0); end
    @(negedge clk);
    total++; if (dv0 !== 1'b0)    begin bad++; $display("FAIL basic_dv_pulse got=%0b exp=0", dv0); end
    total++; if (data0 !== 8'hA5) begin bad++; $display("FAIL basic_hold got=%h exp=a5", data0); end
  endtask

  task automatic test_parity_err();
    int stray;
    @(negedge clk); start = 1'b1;
    drive_frame(8'hA5, 1'b1, -1, stray);
    total++; if (dv0 !== 1'b1)   begin bad++; $display("FAIL err_dv got=%0b exp=1", dv0); end
    total++; if (perr0 !== 1'b1) begin bad++; $display("FAIL err_perr got=%0b exp=1", perr0); end
    total++; if (errc0 !== 8'd1) begin bad++; $display("FAIL err_errc got=%0d exp=1", errc0); end
    @(negedge clk); start = 1'b1;
    drive_frame(8'h01, 1'b1, -1, stray);
    total++; if (data0 !== 8'h01) begin bad++; $display("FAIL ok_data got=%h exp=01", data0); end
    total++; if (perr0 !== 1'b0)  begin bad++; $display("FAIL ok_perr got=%0b exp=0", perr0); end
    total++; if (errc0 !== 8'd1)  begin bad++; $display("FAIL ok_errc got=%0d exp=1", errc0); end
  endtask

  task automatic test_restart_ignored();
    int stray;
    @(negedge clk); start = 1'b1;
    drive_frame(8'h5A, 1'b0, 3, stray);
    total++; if (stray != 0)      begin bad++; $display("FAIL restart_early_dv got=%0d exp=0", stray); end
    total++; if (dv0 !== 1'b1)    begin bad++; $display("FAIL restart_dv got=%0b exp=1", dv0); end
    total++; if (data0 !== 8'h5A) begin bad++; $display("FAIL restart_data got=%h exp=5a", data0); end
    @(negedge clk);
    total++; if (dv0 !== 1'b0)    begin bad++; $display("FAIL restart_dv_after got=%0b exp=0", dv0); end
    total++; if (busy0 !== 1'b0)  begin bad++; $display("FAIL restart_busy got=%0b exp=0", busy0); end
  endtask

  task automatic test_reset_midframe();
    int stray;
    logic [7:0] d;
    d = 8'hFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b exp=1", busy0); end
    for (int i = 0; i < 5; i++) begin
      D_in = d[i];
      @(negedge clk);
    end
    D_in = d[5];
    rstn = 1'b0;
    #1;
    total++; if (data0 !== 8'h00) begin bad++; $display("FAIL mid_data got=%h exp=00", data0); end
    total++; if (errc0 !== 8'd0)  begin bad++; $display("FAIL mid_errc got=%0d exp=0", errc0); end
    total++; if (busy0 !== 1'b0)  begin bad++; $display("FAIL mid_busy_rst got=%0b exp=0", busy0); end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rstn = 1'b1;
      if (dv0) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL mid_no_dv got=%0d exp=0", stray); end
    D_in = 1'b0;
    start = 1'b1;
    drive_frame(8'h3C, 1'b0, -1, stray);
    total++; if (dv0 !== 1'b1)    begin bad++; $display("FAIL after_rst_dv got=%0b exp=1", dv0); end
    total++; if (data0 !== 8'h3C) begin bad++; $display("FAIL after_rst_data got=%h exp=3c", data0); end
    total++; if (perr0 !== 1'b0)  begin bad++; $display("FAIL after_rst_perr got=%0b exp=0", perr0); end
  endtask

  task automatic test_saturate();
    int stray;
    logic [1:0] exp_c [5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); start = 1'b1;
      drive_frame(8'hA5, 1'b1, -1, stray);
      total++;
      if (errc1 !== exp_c[k] || perr1 !== 1'b1) begin
        bad++;
        $display("FAIL sat_%0d got=%0d/%0b exp=%0d/1", k, errc1, perr1, exp_c[k]);
      end
    end
  endtask

  task automatic test_odd_back_to_back();
    int stray;
    do_reset();
    @(negedge clk); start = 1'b1;
    drive_frame(8'h00, 1'b1, -1, stray);
    total++; if (dv2 !== 1'b1)   begin bad++; $display("FAIL odd1_dv got=%0b exp=1", dv2); end
    total++; if (perr2 !== 1'b0) begin bad++; $display("FAIL odd1_perr got=%0b exp=0", perr2); end
    start = 1'b1;
    drive_frame(8'h00, 1'b0, -1, stray);
    total++; if (dv2 !== 1'b1)   begin bad++; $display("FAIL odd2_dv got=%0b exp=1", dv2); end
    total++; if (perr2 !== 1'b1) begin bad++; $display("FAIL odd2_perr got=%0b exp=1", perr2); end
    total++; if (errc2 !== 8'd1) begin bad++; $display("FAIL odd2_errc got=%0d exp=1", errc2); end
    @(negedge clk);
    total++; if (dv2 !== 1'b0)   begin bad++; $display("FAIL odd2_dv_after got=%0b exp=0", dv2); end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; D_in = 1'b0;
    test_reset();
    test_basic();
    test_parity_err();
    test_restart_ignored();
    test_reset_midframe();
    test_saturate();
    test_odd_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
